// File: rtl/rv_fetch_queue.sv
// Instruction prefetch queue: issues sequential fetches, buffers responses tagged with their PC, flushes on redirect.
// Optional misaligned-redirect fault detection is enabled by defining RV_FETCH_MISALIGN_CHK_EN.
module rv_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    output logic        fetch_misalign
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [0:0]  ST_FETCH = 1'b0;
    localparam logic [0:0]  ST_ERR   = 1'b1;
    localparam logic [PW:0] ONE      = (PW+1)'(1);

    logic [0:0]    state;
    logic          started;
    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;
    logic [PW:0]   occupancy;
    logic [PW:0]   outstanding;
    logic [PW:0]   outstanding_next;
    logic [PW:0]   discard;
    logic [PW+1:0] inflight;
    logic [31:0]   fifo_instr [DEPTH];
    logic [31:0]   fifo_pc    [DEPTH];
    logic          req_fire;
    logic          pop;
    logic          push;
    logic          rsp_drop;
    logic          redir_fault;
    logic [31:0]   redir_target;

`ifdef RV_FETCH_MISALIGN_CHK_EN
    assign redir_fault = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    assign redir_fault = 1'b0;
`endif
    assign redir_target = redirect_pc & 32'hFFFF_FFFC;

    // Pops in the current cycle are deliberately not credited to the issue check.
    assign occupancy      = wr_ptr - rd_ptr;
    assign inflight       = {1'b0, occupancy} + {1'b0, outstanding};
    assign imem_req_valid = started && (state == ST_FETCH) && !redirect_valid
                            && (inflight < (PW+2)'(DEPTH));
    assign imem_req_addr  = fetch_pc;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign pop      = dec_valid && dec_ready && !redirect_valid;
    assign rsp_drop = (discard != '0);
    assign push     = imem_rsp_valid && !rsp_drop && !redirect_valid;

    assign outstanding_next = outstanding + (PW+1)'(req_fire) - (PW+1)'(imem_rsp_valid);

    assign dec_valid = (occupancy != '0);
    assign dec_instr = dec_valid ? fifo_instr[rd_ptr[PW-1:0]] : '0;
    assign dec_pc    = dec_valid ? fifo_pc[rd_ptr[PW-1:0]]    : '0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state          <= ST_FETCH;
            started        <= 1'b0;
            fetch_pc       <= RESET_PC;
            rsp_pc         <= RESET_PC;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            outstanding    <= '0;
            discard        <= '0;
            fetch_misalign <= 1'b0;
        end else begin
            started     <= 1'b1;
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                // Everything in flight at this point belongs to the old path.
                wr_ptr         <= '0;
                rd_ptr         <= '0;
                fetch_pc       <= redir_target;
                rsp_pc         <= redir_target;
                discard        <= outstanding_next;
                state          <= redir_fault ? ST_ERR : ST_FETCH;
                fetch_misalign <= redir_fault;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + ONE;
                    rsp_pc <= rsp_pc + 32'd4;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + ONE;
                end
                if (imem_rsp_valid && rsp_drop) begin
                    discard <= discard - ONE;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_instr[wr_ptr[PW-1:0]] <= imem_rsp_data;
            fifo_pc[wr_ptr[PW-1:0]]    <= rsp_pc;
        end
    end

endmodule

// File: tb/tb_rv_fetch_queue.sv
// Scoreboard bench for rv_fetch_queue: directed scenarios push expected PCs; a monitor checks each decoder transfer.
module tb_rv_fetch_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        fetch_misalign;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } mem_req_t;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned mem_lat = 1;
    int unsigned accept_count = 0;
    logic [31:0] exp_q[$];
    mem_req_t    mem_q[$];

    rv_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .CLK(clk), .RST(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc),
        .fetch_misalign(fetch_misalign)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Stimulus moves 2 time units after the edge; the memory model moves at 1.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int unsigned lat);
        rst = 1'b1;
        mem_lat = lat;
        redirect_valid = 1'b0;
        dec_ready = 1'b0;
        imem_req_ready = 1'b1;
        tick();
        tick();
        exp_q.delete();
        rst = 1'b0;
    endtask

    task automatic drain(input string name, input int unsigned bound);
        int unsigned n = 0;
        dec_ready = 1'b1;
        while (exp_q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        dec_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: got %0d entries left expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    // Instruction memory: one response per accepted request, in order, mem_lat cycles after acceptance.
    initial begin
        logic        acc_now;
        logic [31:0] acc_addr;
        int unsigned mem_cyc = 0;
        mem_req_t    m;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        forever begin
            @(negedge clk);
            acc_now = imem_req_valid && imem_req_ready;
            acc_addr = imem_req_addr;
            @(posedge clk);
            #1;
            mem_cyc++;
            if (rst) begin
                mem_q.delete();
                imem_rsp_valid = 1'b0;
                accept_count = 0;
            end else begin
                if (acc_now) begin
                    m.addr = acc_addr;
                    m.due = mem_cyc + mem_lat - 1;
                    mem_q.push_back(m);
                    accept_count++;
                end
                if (mem_q.size() != 0 && mem_q[0].due <= mem_cyc) begin
                    m = mem_q.pop_front();
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data = mem_word(m.addr);
                end else begin
                    imem_rsp_valid = 1'b0;
                end
            end
        end
    end

    // A handshake coinciding with a redirect is flushed, not delivered.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst && dec_valid && dec_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dec_unexpected: got pc %h expected no transfer", dec_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("dec_pc", dec_pc, e);
                    chk("dec_instr", dec_instr, mem_word(e));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned cyc;
        int unsigned acc_snap;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        dec_ready = 1'b0;
        rst = 1'b1;

        // Reset state, then steady 1-cycle memory stream 0,4,8,C
        tick();
        tick();
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_dec_valid", {31'b0, dec_valid}, 32'd0);
        chk("rst_dec_instr", dec_instr, 32'h0);
        chk("rst_dec_pc", dec_pc, 32'h0);
        chk("rst_misalign", {31'b0, fetch_misalign}, 32'd0);
        rst = 1'b0;
        chk("req_valid_before_edge", {31'b0, imem_req_valid}, 32'd0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        exp_q.push_back(32'hC);
        dec_ready = 1'b1;
        cyc = 0;
        while ((exp_q.size() != 0 || cyc < 6) && cyc < 40) begin
            tick();
            cyc++;
            if (cyc == 1) begin
                chk("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
                chk("first_req_addr", imem_req_addr, 32'h0);
            end
            if (cyc >= 3 && cyc <= 6) chk("stream_dec_valid", {31'b0, dec_valid}, 32'd1);
        end
        dec_ready = 1'b0;
        chk("stream_left", exp_q.size(), 32'd0);

        // Decoder stalled: exactly DEPTH requests, then resume after one pop
        do_reset(1);
        repeat (20) tick();
        chk("stall_accepts", accept_count, 32'd4);
        chk("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
        exp_q.push_back(32'h0);
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
        chk("after_pop_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("after_pop_req_addr", imem_req_addr, 32'h10);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        exp_q.push_back(32'hC);
        exp_q.push_back(32'h10);
        drain("stall", 40);

        // Redirect to 0x100 with three requests outstanding
        do_reset(8);
        repeat (4) tick();
        chk("pre_redir_accepts", accept_count, 32'd3);
        redirect(32'h100);
        chk("redir_dec_valid", {31'b0, dec_valid}, 32'd0);
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        exp_q.push_back(32'h108);
        drain("redir100", 120);

        // Redirect coinciding with a response and a pop; C stays outstanding and must be discarded
        do_reset(2);
        repeat (5) tick();
        chk("pre_combo_dec_valid", {31'b0, dec_valid}, 32'd1);
        chk("pre_combo_rsp_valid", {31'b0, imem_rsp_valid}, 32'd1);
        dec_ready = 1'b1;
        redirect(32'h40);
        dec_ready = 1'b0;
        chk("combo_dec_valid", {31'b0, dec_valid}, 32'd0);
        exp_q.push_back(32'h40);
        exp_q.push_back(32'h44);
        drain("combo", 60);

        // Misaligned redirect 0x102, then aligned 0x200
        do_reset(1);
        repeat (3) tick();
        redirect(32'h102);
        acc_snap = accept_count;
`ifdef RV_FETCH_MISALIGN_CHK_EN
        chk("misalign_set", {31'b0, fetch_misalign}, 32'd1);
        repeat (5) begin
            tick();
            chk("err_req_valid", {31'b0, imem_req_valid}, 32'd0);
        end
        chk("err_accepts", accept_count, acc_snap);
        chk("err_dec_valid", {31'b0, dec_valid}, 32'd0);
`else
        chk("misalign_tied", {31'b0, fetch_misalign}, 32'd0);
        repeat (5) tick();
        chk("masked_accepts_grew", {31'b0, accept_count > acc_snap}, 32'd1);
        exp_q.push_back(32'h100);
        drain("masked", 40);
`endif
        redirect(32'h200);
        chk("misalign_clear", {31'b0, fetch_misalign}, 32'd0);
        exp_q.push_back(32'h200);
        exp_q.push_back(32'h204);
        drain("resume200", 40);

        // Asynchronous reset with two requests outstanding
        do_reset(6);
        repeat (3) tick();
        chk("pre_rst_accepts", accept_count, 32'd2);
        #1;
        rst = 1'b1;
        #1;
        chk("async_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("async_req_addr", imem_req_addr, 32'h0);
        chk("async_dec_valid", {31'b0, dec_valid}, 32'd0);
        chk("async_dec_instr", dec_instr, 32'h0);
        chk("async_dec_pc", dec_pc, 32'h0);
        chk("async_misalign", {31'b0, fetch_misalign}, 32'd0);
        mem_lat = 1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("post_rst_req_addr", imem_req_addr, 32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        drain("post_rst", 40);

        // fetch_pc wraps past the top of the address space
        do_reset(1);
        redirect(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        drain("wrap", 40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rv_fetch_queue.md
RV_FETCH_QUEUE -- requirements
Module: rv_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4 (power of two, 2..16): prefetch FIFO entries.
REQ-002 SHALL have parameter RESET_PC, default 32'h0: first fetch address after reset.
REQ-003 SHALL have port CLK  input  1  single clock; all state rising-edge triggered.
REQ-004 SHALL have port RST  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port imem_req_valid  output  1  fetch request to instruction memory.
REQ-006 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-007 SHALL have port imem_req_addr  output  32  word-aligned fetch address.
REQ-008 SHALL have port imem_rsp_valid  input  1  in-order response strobe, one per accepted request, no earlier than the cycle after acceptance.
REQ-009 SHALL have port imem_rsp_data  input  32  instruction word.
REQ-010 SHALL have port redirect_valid  input  1  branch/jump redirect from exec/writeback.
REQ-011 SHALL have port redirect_pc  input  32  redirect target.
REQ-012 SHALL have port dec_valid  output  1  instruction available to decoder.
REQ-013 SHALL have port dec_ready  input  1  decoder consumes instruction.
REQ-014 SHALL have port dec_instr  output  32  head instruction.
REQ-015 SHALL have port dec_pc  output  32  address of dec_instr.
REQ-016 SHALL have port fetch_misalign  output  1  misaligned-redirect fault flag.

Function
REQ-017 SHALL transfer on the imem request side when imem_req_valid and imem_req_ready are both high in the same cycle; fetch_pc then advances by 4.
REQ-018 SHALL transfer to the decoder when dec_valid and dec_ready are both high; FIFO head then pops.
REQ-019 SHALL assert imem_req_valid only when occupancy + outstanding < DEPTH, state is FETCH and redirect_valid is low; a pop in the same cycle SHALL NOT count toward this check.
REQ-020 SHALL hold imem_req_addr stable while imem_req_valid is high and not accepted.
REQ-021 SHALL write each non-discarded response into the FIFO tagged with its request address; dec_valid rises the cycle after imem_rsp_valid (1-cycle latency, no bypass).
REQ-022 SHALL sustain one instruction per cycle with a memory that responds one cycle after acceptance and dec_ready held high.
REQ-023 SHALL, on redirect_valid: empty the FIFO; set fetch_pc to redirect_pc; load the discard counter with outstanding minus any response arriving that same cycle; dec_valid low the following cycle.
REQ-024 SHALL give redirect priority over a simultaneous push, pop or request acceptance; an accepted request SHALL be ignored.
REQ-025 SHALL drop responses while the discard counter is non-zero, decrementing it once per response; new requests MAY issue during discard.
REQ-026 SHALL hold outstanding as a counter: +1 per accepted request, -1 per response, both in one cycle leaves it unchanged.
REQ-027 SHALL implement FSM states FETCH and ERR; FETCH->ERR on a misaligned redirect (REQ-033); ERR->FETCH on an aligned redirect; ERR issues no requests.
REQ-028 SHALL wrap FIFO pointers modulo DEPTH; full and empty are distinguished by an extra pointer bit.
REQ-029 SHALL wrap fetch_pc from 32'hFFFF_FFFC to 32'h0 without fault.

Reset
REQ-030 SHALL, while RST is high, force: fetch_pc=RESET_PC, FIFO empty, outstanding=0, discard=0, state FETCH, imem_req_valid=0, dec_valid=0, dec_instr=0, dec_pc=0, fetch_misalign=0.
REQ-031 SHALL drop all responses to pre-reset requests when RST asserts mid-transaction; memory is reset with the block.
REQ-032 SHALL raise imem_req_valid no earlier than the first rising CLK edge after RST deasserts.

Configuration
REQ-033 SHALL, with RV_FETCH_MISALIGN_CHK_EN defined, treat redirect_pc[1:0]!=0 as a fault: enter ERR, set fetch_misalign=1 (held until the next aligned redirect or reset).
REQ-034 SHALL, without RV_FETCH_MISALIGN_CHK_EN, force redirect_pc[1:0] to 0, never enter ERR, and tie fetch_misalign to 0.

Verification
REQ-035 SHALL cover reset release, 1-cycle memory, dec_ready=1 -> dec_pc sequence 0,4,8,C with dec_valid continuous from cycle 3.
REQ-036 SHALL cover dec_ready=0 with DEPTH=4 -> exactly 4 requests accepted, then imem_req_valid=0 until the first pop.
REQ-037 SHALL cover redirect to 32'h100 with 3 requests outstanding -> those 3 responses dropped, first dec_pc=32'h100.
REQ-038 SHALL cover redirect in the same cycle as a response and a pop -> FIFO empty next cycle, discard=outstanding-1.
REQ-039 SHALL cover redirect_pc=32'h102 with the macro -> fetch_misalign=1, no requests; then redirect 32'h200 -> resumes at 32'h200; without the macro the same stimulus yields first dec_pc=32'h100.
REQ-040 SHALL cover RST asserted with 2 requests outstanding -> all outputs at reset values asynchronously, first post-reset imem_req_addr=RESET_PC.
